// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver:
// the state encoding, the parity-type constants and the majority vote.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the serial line plus three mid-bit samples
// and their majority vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RX_IN,
  input  logic [$clog2(OVERSAMPLE)-1:0] edge_cnt,
  output logic                          rx_s,
  output logic                          sampled_bit
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] M_LO  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] M_MID = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] M_HI  = CNT_W'(OVERSAMPLE / 2 + 1);

  logic       sync1_q;
  logic       rx_s_q;
  logic [2:0] smp_q;
  logic       smp_hi_d;

  // synchroniser chain and sample capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      smp_q   <= 3'b111;
    end else begin
      sync1_q <= RX_IN;
      rx_s_q  <= sync1_q;
      if (edge_cnt == M_LO)  smp_q[0] <= rx_s_q;
      if (edge_cnt == M_MID) smp_q[1] <= rx_s_q;
      if (edge_cnt == M_HI)  smp_q[2] <= rx_s_q;
    end
  end

  // the third sample is bypassed so the vote is ready in the M+1 cycle itself
  always_comb begin
    smp_hi_d = smp_q[2];
    if (edge_cnt == M_HI) begin
      smp_hi_d = rx_s_q;
    end else begin
      smp_hi_d = smp_q[2];
    end
  end

  assign rx_s        = rx_s_q;
  assign sampled_bit = maj3(smp_q[0], smp_q[1], smp_hi_d);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, bit/edge counters, shift register,
// parity and stop checks, and registered result pulses.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX_IN,
  input  logic              par_en,
  input  logic              par_typ,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              par_err,
  output logic              stop_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] DECIDE   = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] p_data_q;
  logic              par_en_q;
  logic              par_typ_q;
  logic              par_bad_q;
  logic              data_valid_q;
  logic              par_err_q;
  logic              stop_err_q;
  logic              busy_q;
  logic              rx_s;
  logic              sampled_bit;
  logic              wrap_s;
  logic              decide_s;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .edge_cnt   (edge_cnt_q),
    .rx_s       (rx_s),
    .sampled_bit(sampled_bit)
  );

  assign wrap_s   = (edge_cnt_q == CNT_MAX);
  assign decide_s = (edge_cnt_q == DECIDE);

  // frame FSM with counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      edge_cnt_q   <= wrap_s ? '0 : edge_cnt_q + CNT_W'(1);
      bit_cnt_q    <= wrap_s ? bit_cnt_q + BIT_W'(1) : bit_cnt_q;
      case (state_q)
        S_IDLE: begin
          edge_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (!rx_s) begin
            state_q   <= S_START;
            busy_q    <= 1'b1;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            par_bad_q <= 1'b0;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_START: begin
          if (decide_s && sampled_bit) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end else if (wrap_s) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
          end else begin
            state_q <= S_START;
          end
        end
        S_DATA: begin
          if (decide_s) begin
            shift_q <= {sampled_bit, shift_q[DATA_W-1:1]};
          end else begin
            shift_q <= shift_q;
          end
          if (wrap_s && (bit_cnt_q == LAST_BIT)) begin
            state_q   <= par_en_q ? S_PARITY : S_STOP;
            bit_cnt_q <= '0;
          end else begin
            state_q <= S_DATA;
          end
        end
        S_PARITY: begin
          if (decide_s) begin
            par_bad_q <= sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
          end else begin
            par_bad_q <= par_bad_q;
          end
          if (wrap_s) begin
            state_q   <= S_STOP;
            bit_cnt_q <= '0;
          end else begin
            state_q <= S_PARITY;
          end
        end
        S_STOP: begin
          // leave half a bit early so a back-to-back start edge is not missed
          if (decide_s) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            par_err_q  <= par_bad_q;
            stop_err_q <= ~sampled_bit;
            if (sampled_bit && !par_bad_q) begin
              p_data_q     <= shift_q;
              data_valid_q <= 1'b1;
            end else begin
              p_data_q <= p_data_q;
            end
          end else begin
            state_q <= S_STOP;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          edge_cnt_q <= '0;
          bit_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stop_err   = stop_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (8-bit/x8 and 9-bit/x16) driven by a
// frame generator, with expected result pulses checked from a scoreboard.
module tb_uart_rx_param;

  typedef struct {
    logic [2:0] flags;   // {data_valid, par_err, stop_err}
    logic [8:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1;
  logic       rx9 = 1'b1;
  logic       pen8 = 1'b0, ptyp8 = 1'b0, pen9 = 1'b0, ptyp9 = 1'b0;
  logic [7:0] p8;
  logic [8:0] p9;
  logic       dv8, pe8, se8, busy8;
  logic       dv9, pe9, se9, busy9;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       q8[$];
  exp_t       q9[$];
  logic [8:0] lg8 = '0;
  logic [8:0] lg9 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.DATA_W(8), .OVERSAMPLE(8)) u8 (
    .clk(clk), .rst(rst), .RX_IN(rx8), .par_en(pen8), .par_typ(ptyp8),
    .p_data(p8), .data_valid(dv8), .par_err(pe8), .stop_err(se8), .busy(busy8)
  );

  uart_rx_param #(.DATA_W(9), .OVERSAMPLE(16)) u9 (
    .clk(clk), .rst(rst), .RX_IN(rx9), .par_en(pen9), .par_typ(ptyp9),
    .p_data(p9), .data_valid(dv9), .par_err(pe9), .stop_err(se9), .busy(busy9)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // sends one frame; gbit/goff invert a single cycle of one bit (-1 = none)
  task automatic send_frame(input int sel, input logic [8:0] data, input logic pe,
                            input logic pt, input logic pbit, input logic stop,
                            input int gbit, input int goff);
    int          os, dw, nb;
    logic [11:0] bits;
    logic        par, perr, v;
    exp_t        e;
    os = (sel == 0) ? 8 : 16;
    dw = (sel == 0) ? 8 : 9;
    if (sel == 0) begin pen8 = pe; ptyp8 = pt; end
    else begin pen9 = pe; ptyp9 = pt; end
    bits = '0;
    nb = 1;
    for (int i = 0; i < dw; i++) begin bits[nb] = data[i]; nb++; end
    if (pe) begin bits[nb] = pbit; nb++; end
    bits[nb] = stop;
    nb++;
    par = 1'b0;
    for (int i = 0; i < dw; i++) par = par ^ data[i];
    perr = pe && (pbit != (par ^ pt));
    e.flags = {stop && !perr, perr, !stop};
    if (sel == 0) begin
      if (e.flags[2]) lg8 = data;
      e.data = lg8;
    end else begin
      if (e.flags[2]) lg9 = data;
      e.data = lg9;
    end
    e.cyc = cyc + 3 + (1 + dw + int'(pe)) * os + os / 2 + 2;
    if (sel == 0) q8.push_back(e); else q9.push_back(e);
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < os; j++) begin
        v = bits[k] ^ ((k == gbit) && (j == goff));
        if (sel == 0) rx8 = v; else rx9 = v;
        tick();
      end
    end
    if (sel == 0) rx8 = 1'b1; else rx9 = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (q8.size() != 0 || q9.size() != 0); i++) tick();
    chk_eq("drain_timeout", q8.size() + q9.size(), 0);
  endtask

  // result-pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (dv8 | pe8 | se8) begin
      if (q8.size() == 0) begin
        chk_eq("unexpected_pulse8", {29'd0, dv8, pe8, se8}, 32'd0);
      end else begin
        e = q8.pop_front();
        chk_eq("flags8", {29'd0, dv8, pe8, se8}, {29'd0, e.flags});
        chk_eq("p_data8", {24'd0, p8}, {23'd0, e.data});
        chk_eq("latency8", cyc, e.cyc);
      end
    end
    if (dv9 | pe9 | se9) begin
      if (q9.size() == 0) begin
        chk_eq("unexpected_pulse9", {29'd0, dv9, pe9, se9}, 32'd0);
      end else begin
        e = q9.pop_front();
        chk_eq("flags9", {29'd0, dv9, pe9, se9}, {29'd0, e.flags});
        chk_eq("p_data9", {23'd0, p9}, {23'd0, e.data});
        chk_eq("latency9", cyc, e.cyc);
      end
    end
  end

  initial begin
    idle(4);
    chk_eq("rst_p_data8", {24'd0, p8}, 32'd0);
    chk_eq("rst_busy8", {31'd0, busy8}, 32'd0);
    chk_eq("rst_p_data9", {23'd0, p9}, 32'd0);
    chk_eq("rst_busy9", {31'd0, busy9}, 32'd0);
    rst = 1'b0;
    idle(5);

    // 8N1 basic frame
    send_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    drain(); idle(10);

    // even parity, good then bad parity bit
    send_frame(0, 9'h03C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
    drain(); idle(10);
    send_frame(0, 9'h03C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0);
    drain(); idle(20);

    // framing error followed by a clean frame
    send_frame(0, 9'h081, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    drain(); idle(20);
    send_frame(0, 9'h042, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    drain(); idle(10);

    // short low pulse: false start rejected
    rx8 = 1'b0;
    idle(3);
    rx8 = 1'b1;
    chk_eq("glitch_busy_high", {31'd0, busy8}, 32'd1);
    idle(10);
    chk_eq("glitch_busy_low", {31'd0, busy8}, 32'd0);
    idle(10);

    // one-cycle spike inside data bit 0, aimed at the middle sample
    send_frame(0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 5);
    drain(); idle(10);

    // back-to-back frames, no idle gap
    send_frame(0, 9'h055, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    send_frame(0, 9'h0AA, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    drain(); idle(10);

    // reset in the middle of data bit 4
    rx8 = 1'b0;
    idle(8);
    for (int k = 0; k < 4 * 8 + 4; k++) begin
      rx8 = k[3];
      tick();
    end
    chk_eq("busy_before_rst", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    rx8 = 1'b1;
    tick();
    lg8 = '0;
    lg9 = '0;
    chk_eq("in_rst_p_data8", {24'd0, p8}, 32'd0);
    chk_eq("in_rst_busy8", {31'd0, busy8}, 32'd0);
    chk_eq("in_rst_pulses8", {29'd0, dv8, pe8, se8}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(5);
    send_frame(0, 9'h07E, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    drain(); idle(10);

    // wide instance: 9 data bits, x16, odd parity
    send_frame(1, 9'h1FF, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
    drain(); idle(10);
    send_frame(1, 9'h0A3, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0);
    drain(); idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It is the successor to the fixed 8-bit, no-parity receive path: data width and oversampling ratio are configurable, and parity is selectable at runtime. It adds a 2-flop input synchroniser, 3-sample majority voting, a parity check, a stop-bit (framing) check and a one-cycle data_valid strobe. It sits directly behind the serial input pin and feeds the parallel consumer.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 8, clk cycles per bit; legal values 8, 16, 32.

Ports:
clk  input  1  system clock, one clock domain.
rst  input  1  reset, synchronous, active-high.
RX_IN  input  1  serial line; asynchronous; idles high.
par_en  input  1  1 = parity bit follows the data bits.
par_typ  input  1  0 = even parity, 1 = odd parity.
p_data  output  DATA_W  last good word received, LSB = first bit.
data_valid  output  1  one-cycle pulse when a good frame completes.
par_err  output  1  one-cycle pulse on a parity mismatch.
stop_err  output  1  one-cycle pulse when the stop bit samples 0.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high) forces the following, from the next edge:
  - p_data=0, data_valid=0, par_err=0, stop_err=0, busy=0.
  - Synchroniser flops=1, FSM=IDLE, edge_cnt=0, bit_cnt=0.
- A reset mid-frame abandons the frame. No pulse is produced.
- Input synchroniser:
  - RX_IN passes through 2 flops. Only the synchronised value (rx_s) is used anywhere else.
- Counters:
  - edge_cnt runs 0..OVERSAMPLE-1 and wraps to 0. Each wrap advances bit_cnt.
  - bit_cnt width is $clog2(DATA_W+1). It is cleared on entry to each state.
- Sampling:
  - rx_s is captured at edge_cnt = M-1, M and M+1, where M = OVERSAMPLE/2.
  - The bit value is the majority of the three samples, decided at edge_cnt = M+1.
- par_en and par_typ are latched on the IDLE->START transition. They are ignored mid-frame.
- FSM transitions:
  - IDLE: when rx_s=0, go to START with edge_cnt=0.
  - START:
    - Majority = 1 (glitch): go to IDLE at the decision cycle, with no output.
    - Majority = 0: go to DATA at the edge_cnt wrap.
  - DATA:
    - Shift each decided bit into the shift register, LSB first.
    - After bit DATA_W-1 wraps, go to PARITY if par_en, otherwise STOP.
  - PARITY:
    - Compare the decided bit with ^data XOR par_typ.
    - Record the mismatch. Go to STOP at the wrap.
  - STOP: at the decision cycle, go to IDLE (half a bit early, so back-to-back frames are accepted).
- Output update, on the edge after the STOP decision:
  - Stop bit = 1 and no parity mismatch: p_data <= shift register; data_valid=1.
  - Parity mismatch: par_err=1, data_valid=0, p_data is held.
  - Stop bit = 0: stop_err=1, data_valid=0, p_data is held.
  - par_err and stop_err may pulse in the same cycle.
- All pulses are exactly 1 cycle wide.
- Latency:
  - Let F = 1 + DATA_W + par_en.
  - data_valid rises 3 + F*OVERSAMPLE + M + 2 clk edges after RX_IN first falls.
  - For 8N1 with OVERSAMPLE=8 this is 81 edges.
- Boundary conditions:
  - A falling edge during the STOP tail (before the decision) is ignored.
  - rx_s=0 in the first IDLE cycle starts a new frame immediately.
  - A single-sample glitch inside any bit is outvoted by the majority.
  - A line held low continuously gives stop_err on every frame. The receiver restarts at once because rx_s is still 0.

Decomposition:
- Package uart_rx_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP; 3-bit localparams);
  - the parity-type constants PAR_EVEN=0 and PAR_ODD=1.
- Sub-module uart_rx_sampler holds:
  - the 2-flop synchroniser;
  - the three sample registers and the majority vote.
  - Its ports are clk, rst, RX_IN, edge_cnt → rx_s, sampled_bit.
- The FSM, counters, shift register, parity and outputs stay in uart_rx_param.

Test Plan:
1. DATA_W=8, OVERSAMPLE=8, par_en=0; send 0xA5 (8N1) → data_valid high for 1 cycle exactly 81 edges after the start fall; p_data=0xA5; no error pulses.
2. par_en=1, par_typ=0; send 0x3C with parity bit 0 → p_data=0x3C, data_valid pulse. Resend 0x3C with parity bit 1 → par_err pulse, data_valid=0, p_data stays 0x3C.
3. Send 0x81 with the stop bit driven 0 → stop_err pulse, data_valid=0. Then send 0x42 normally → p_data=0x42.
4. Drive RX_IN low for 3 cycles, then high → busy pulses, FSM returns to IDLE, no output pulses. Inject a 1-cycle high spike at edge_cnt=M inside data bit 0 (value 0) of frame 0x00 → p_data=0x00.
5. Send 0x55 then 0xAA back-to-back (one stop bit, no gap) → two data_valid pulses 80 cycles apart; p_data=0x55, then 0xAA.
6. Assert rst during DATA bit 4, then send 0x7E → outputs are 0 during reset with no spurious pulse; p_data=0x7E afterwards. Repeat with OVERSAMPLE=16, DATA_W=9, par_typ=1, data 0x1FF → valid.
